adc_sample_packer: RTL and testbench

Capture-control and width-packing stage that sits directly upstream of the ADC-to-AXI-Stream stage. It accepts narrow ADC sample beats and packs every `ADC_DWIDTH/IN_DWIDTH` beats into one wide word. It drives `adc_data`, `adc_data_valid` and `adc_capture_en` into the streaming stage. Capture is started by software, either immediately or gated by an external trigger edge, and can be stopped at any time.

---
 rtl/adc_sample_packer.sv | 123 ++++++++++++
 tb/tb_adc_sample_packer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_packer.sv
// Capture control plus narrow-to-wide packing ahead of the ADC streaming stage.
// Beats fill lanes LSB-first; a full word is strobed out one cycle after its last beat.
module adc_sample_packer #(
    parameter int IN_DWIDTH  = 64,
    parameter int ADC_DWIDTH = 256
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [IN_DWIDTH-1:0]  sample_data_i,
    input  logic                  sample_valid_i,
    input  logic                  capture_start_i,
    input  logic                  capture_stop_i,
    input  logic                  trig_mode_i,
    input  logic                  trigger_i,
    output logic                  adc_capture_en_o,
    output logic [ADC_DWIDTH-1:0] adc_data_o,
    output logic                  adc_data_valid_o,
    output logic [31:0]           word_count_o,
    output logic [1:0]            state_o
);
    localparam int R  = ADC_DWIDTH / IN_DWIDTH;
    localparam int LW = $clog2(R);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  trig_q, trig_d;
    logic [LW-1:0]         lane_cnt_q, lane_cnt_d;
    logic [31:0]           word_count_q, word_count_d;
    logic                  data_valid_q, data_valid_d;
    logic [ADC_DWIDTH-1:0] shadow_q, shadow_d;
    logic [ADC_DWIDTH-1:0] adc_data_q, adc_data_d;

    logic trig_edge;
    logic start_clr;
    logic accept;
    logic word_done;

    always_comb begin
        trig_edge = trigger_i & ~trig_q;
        trig_d    = trigger_i;
        state_d   = state_q;
        case (state_q)
            ST_IDLE: begin
                if (capture_start_i && !capture_stop_i)
                    state_d = trig_mode_i ? ST_ARMED : ST_RUN;
            end
            ST_ARMED: begin
                if (capture_stop_i)
                    state_d = ST_IDLE;
                else if (trig_edge)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (capture_stop_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stop in the same cycle as a beat kills the beat, and any partial word with it.
    always_comb begin
        start_clr = (state_q == ST_IDLE) && capture_start_i && !capture_stop_i;
        accept    = (state_q == ST_RUN) && sample_valid_i && !capture_stop_i;
        word_done = accept && (lane_cnt_q == LW'(R - 1));

        lane_cnt_d = lane_cnt_q;
        if (start_clr || capture_stop_i)
            lane_cnt_d = '0;
        else if (accept)
            lane_cnt_d = lane_cnt_q + LW'(1);

        word_count_d = word_count_q;
        if (start_clr)
            word_count_d = '0;
        else if (word_done && word_count_q != 32'hFFFF_FFFF)
            word_count_d = word_count_q + 32'd1;

        data_valid_d = word_done;
    end

    // Data path: shadow_d already holds the current beat, so the completed word is shadow_d.
    always_comb begin
        shadow_d = shadow_q;
        for (int l = 0; l < R; l++) begin
            if (accept && lane_cnt_q == LW'(l))
                shadow_d[l*IN_DWIDTH +: IN_DWIDTH] = sample_data_i;
        end
        adc_data_d = adc_data_q;
        if (word_done)
            adc_data_d = shadow_d;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            trig_q       <= 1'b0;
            lane_cnt_q   <= '0;
            word_count_q <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_q       <= trig_d;
            lane_cnt_q   <= lane_cnt_d;
            word_count_q <= word_count_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shadow_q   <= shadow_d;
        adc_data_q <= adc_data_d;
    end

    assign adc_capture_en_o = (state_q == ST_RUN);
    assign adc_data_o       = adc_data_q;
    assign adc_data_valid_o = data_valid_q;
    assign word_count_o     = word_count_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_adc_sample_packer.sv
// Directed bench for adc_sample_packer (IN_DWIDTH=64, R=4) with a queue scoreboard
// drained by a monitor on every output strobe.
module tb_adc_sample_packer;
    localparam int IW = 64;
    localparam int AW = 256;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [IW-1:0] sample_data_i;
    logic          sample_valid_i;
    logic          capture_start_i;
    logic          capture_stop_i;
    logic          trig_mode_i;
    logic          trigger_i;
    logic          adc_capture_en_o;
    logic [AW-1:0] adc_data_o;
    logic          adc_data_valid_o;
    logic [31:0]   word_count_o;
    logic [1:0]    state_o;

    typedef struct {
        logic [AW-1:0] data;
        logic [31:0]   cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    adc_sample_packer #(.IN_DWIDTH(IW), .ADC_DWIDTH(AW)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .sample_data_i    (sample_data_i),
        .sample_valid_i   (sample_valid_i),
        .capture_start_i  (capture_start_i),
        .capture_stop_i   (capture_stop_i),
        .trig_mode_i      (trig_mode_i),
        .trigger_i        (trigger_i),
        .adc_capture_en_o (adc_capture_en_o),
        .adc_data_o       (adc_data_o),
        .adc_data_valid_o (adc_data_valid_o),
        .word_count_o     (word_count_o),
        .state_o          (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] w4(input logic [IW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic push(input logic [AW-1:0] d, input logic [31:0] c);
        exp_t e;
        e.data = d;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        sample_valid_i  = 1'b0;
        capture_start_i = 1'b0;
        capture_stop_i  = 1'b0;
    endtask

    // Four consecutive beats; strobe must appear only right after the fourth.
    task automatic beats4(input string tag, input logic [IW-1:0] base);
        for (int k = 0; k < 4; k++) begin
            sample_valid_i = 1'b1;
            sample_data_i  = base + IW'(k);
            tick();
            chk({tag, "_strobe"}, AW'(adc_data_valid_o), AW'(k == 3));
        end
        sample_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (adc_data_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data %h expected no strobe", adc_data_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word_data", adc_data_o, e.data);
                chk("word_count", AW'(word_count_o), AW'(e.cnt));
            end
        end
    end

    initial begin
        reset_i = 1'b1;
        sample_data_i = '0;
        trig_mode_i = 1'b0;
        trigger_i = 1'b0;
        idle_in();
        tick();
        tick();
        reset_i = 1'b0;
        chk("rst_state", AW'(state_o), AW'(0));
        chk("rst_en", AW'(adc_capture_en_o), AW'(0));
        chk("rst_valid", AW'(adc_data_valid_o), AW'(0));
        chk("rst_count", AW'(word_count_o), AW'(0));

        // 1: immediate mode, continuous beats
        capture_start_i = 1'b1;
        tick();
        capture_start_i = 1'b0;
        chk("t1_state", AW'(state_o), AW'(2));
        chk("t1_en", AW'(adc_capture_en_o), AW'(1));
        push(w4(1, 2, 3, 4), 1);
        push(w4(5, 6, 7, 8), 2);
        for (int k = 1; k <= 8; k++) begin
            sample_valid_i = 1'b1;
            sample_data_i  = IW'(k);
            tick();
            chk("t1_strobe", AW'(adc_data_valid_o), AW'(k % 4 == 0));
        end
        sample_valid_i = 1'b0;
        tick();
        chk("t1_count", AW'(word_count_o), AW'(2));
        chk("t1_hold", adc_data_o, w4(5, 6, 7, 8));

        // 2: gapped valid, garbage on invalid cycles
        push(w4(1, 2, 3, 4), 3);
        for (int i = 0; i < 8; i++) begin
            sample_valid_i = (i % 2 == 0);
            sample_data_i  = (i % 2 == 0) ? IW'(i / 2 + 1) : 64'hDEAD_BEEF_0000_00EE;
            tick();
            chk("t2_strobe", AW'(adc_data_valid_o), AW'(i == 6));
        end
        sample_valid_i = 1'b0;

        // 3: trigger mode, trigger already high at arm time
        capture_stop_i = 1'b1;
        trigger_i = 1'b1;
        tick();
        capture_stop_i = 1'b0;
        chk("t3_stopped", AW'(state_o), AW'(0));
        tick();
        trig_mode_i = 1'b1;
        capture_start_i = 1'b1;
        tick();
        capture_start_i = 1'b0;
        chk("t3_armed", AW'(state_o), AW'(1));
        chk("t3_count_clr", AW'(word_count_o), AW'(0));
        sample_valid_i = 1'b1;
        sample_data_i = 64'h55;
        tick();
        tick();
        chk("t3_still_armed", AW'(state_o), AW'(1));
        chk("t3_en_low", AW'(adc_capture_en_o), AW'(0));
        trigger_i = 1'b0;
        tick();
        trigger_i = 1'b1;
        sample_data_i = 64'h99;
        tick();
        sample_valid_i = 1'b0;
        chk("t3_run", AW'(state_o), AW'(2));
        chk("t3_en", AW'(adc_capture_en_o), AW'(1));
        push(w4(1, 2, 3, 4), 1);
        beats4("t3", 1);

        // 4: stop mid-word
        trig_mode_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample_valid_i = 1'b1;
            sample_data_i = 64'hA + IW'(k);
            tick();
        end
        sample_data_i = 64'hD;
        capture_stop_i = 1'b1;
        tick();
        idle_in();
        chk("t4_en", AW'(adc_capture_en_o), AW'(0));
        chk("t4_state", AW'(state_o), AW'(0));
        chk("t4_nostrobe", AW'(adc_data_valid_o), AW'(0));
        tick();
        tick();
        capture_start_i = 1'b1;
        tick();
        capture_start_i = 1'b0;
        chk("t4_count_clr", AW'(word_count_o), AW'(0));
        push(w4(1, 2, 3, 4), 1);
        beats4("t4", 1);
        chk("t4_count", AW'(word_count_o), AW'(1));

        // 5: start+stop in IDLE, start during RUN
        capture_stop_i = 1'b1;
        tick();
        capture_start_i = 1'b1;
        tick();
        idle_in();
        chk("t5_idle", AW'(state_o), AW'(0));
        capture_start_i = 1'b1;
        tick();
        capture_start_i = 1'b0;
        push(w4(1, 2, 3, 4), 1);
        beats4("t5a", 1);
        capture_start_i = 1'b1;
        tick();
        capture_start_i = 1'b0;
        chk("t5_run_kept", AW'(state_o), AW'(2));
        chk("t5_count_kept", AW'(word_count_o), AW'(1));
        push(w4(5, 6, 7, 8), 2);
        beats4("t5b", 5);

        // 6: reset mid-run
        capture_stop_i = 1'b1;
        tick();
        capture_stop_i = 1'b0;
        capture_start_i = 1'b1;
        tick();
        capture_start_i = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            sample_valid_i = 1'b1;
            sample_data_i = IW'(k);
            tick();
        end
        reset_i = 1'b1;
        sample_data_i = 64'h3;
        tick();
        chk("t6_state", AW'(state_o), AW'(0));
        chk("t6_en", AW'(adc_capture_en_o), AW'(0));
        chk("t6_valid", AW'(adc_data_valid_o), AW'(0));
        chk("t6_count", AW'(word_count_o), AW'(0));
        reset_i = 1'b0;
        sample_data_i = 64'h4;
        tick();
        sample_valid_i = 1'b0;
        chk("t6_nostrobe", AW'(adc_data_valid_o), AW'(0));
        capture_start_i = 1'b1;
        tick();
        capture_start_i = 1'b0;
        push(w4(64'h11, 64'h12, 64'h13, 64'h14), 1);
        beats4("t6", 64'h11);
        tick();
        tick();
        tick();
        chk("sb_drained", AW'(sb.size()), AW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
